// File: rtl/quad_state_monitor.sv
// Receiving-end checker for the four-phase sequencer: verifies encoded/one-hot
// agreement and 0->1->2->3->0 ordering, measures per-phase dwell, reports lock.
module quad_state_monitor #(
  parameter int unsigned DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             state,
  input  logic                   state_0,
  input  logic                   state_1,
  input  logic                   state_2,
  input  logic                   state_3,
  input  logic                   clear_errors,
  output logic [DWELL_WIDTH-1:0] dwell_0,
  output logic [DWELL_WIDTH-1:0] dwell_1,
  output logic [DWELL_WIDTH-1:0] dwell_2,
  output logic [DWELL_WIDTH-1:0] dwell_3,
  output logic                   locked,
  output logic                   cycle_done,
  output logic [31:0]            cycle_count,
  output logic                   err_sequence,
  output logic                   err_decode,
  output logic                   err_overflow
);

  localparam logic [DWELL_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} fsm_t;

  fsm_t                   fsm_q, fsm_d;
  logic [1:0]             s_q, p_q;
  logic [3:0]             s_hot_q;
  logic                   s_v, p_v;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic                   trans, legal, illegal, dec_bad, sat_hit, fault, wrap;
  logic                   capture, done;

  // Valid bits keep reset-value samples out of the transition and decode tests
  always_comb begin
    trans   = s_v & p_v & (s_q != p_q);
    legal   = trans & (s_q == 2'(p_q + 2'd1));
    illegal = trans & ~legal;
    wrap    = legal & (s_q == 2'd0);
    dec_bad = s_v & (s_hot_q != (4'b0001 << s_q));
    if (trans)
      cnt_d = DWELL_WIDTH'(1);
    else if (cnt_q == CNT_MAX)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + DWELL_WIDTH'(1);
    sat_hit = ~trans & (cnt_q == CNT_MAX - DWELL_WIDTH'(1));
    fault   = illegal | dec_bad | sat_hit;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) fsm_q <= SEARCH;
    else          fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d   = fsm_q;
    capture = 1'b0;
    done    = 1'b0;
    case (fsm_q)
      SEARCH: begin
        if (wrap && !fault) fsm_d = TRACK;
      end
      TRACK: begin
        capture = legal & ~fault;
        if (fault) begin
          fsm_d = SEARCH;
        end else if (wrap) begin
          fsm_d = LOCKED;
          done  = 1'b1;
        end
      end
      LOCKED: begin
        capture = legal & ~fault;
        if (fault)     fsm_d = SEARCH;
        else if (wrap) done  = 1'b1;
      end
      default: fsm_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_q          <= 2'd0;
      s_hot_q      <= 4'd0;
      p_q          <= 2'd0;
      s_v          <= 1'b0;
      p_v          <= 1'b0;
      cnt_q        <= '0;
      dwell_0      <= '0;
      dwell_1      <= '0;
      dwell_2      <= '0;
      dwell_3      <= '0;
      locked       <= 1'b0;
      cycle_done   <= 1'b0;
      cycle_count  <= 32'd0;
      err_sequence <= 1'b0;
      err_decode   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      s_q     <= state;
      s_hot_q <= {state_3, state_2, state_1, state_0};
      s_v     <= 1'b1;
      p_q     <= s_q;
      p_v     <= s_v;
      cnt_q   <= cnt_d;
      if (capture) begin
        case (p_q)
          2'd0:    dwell_0 <= cnt_q;
          2'd1:    dwell_1 <= cnt_q;
          2'd2:    dwell_2 <= cnt_q;
          default: dwell_3 <= cnt_q;
        endcase
      end
      locked     <= (fsm_d == LOCKED);
      cycle_done <= done;
      if (done) cycle_count <= cycle_count + 32'd1;
      // A new error in the clearing cycle wins over the clear
      err_sequence <= (err_sequence & ~clear_errors) | illegal;
      err_decode   <= (err_decode   & ~clear_errors) | dec_bad;
      err_overflow <= (err_overflow & ~clear_errors) | sat_hit;
    end
  end

endmodule

// File: doc/quad_state_monitor.md
# quad_state_monitor

Receiving-end checker for the four-phase timing sequence produced by `quad_state_machine`. It samples the encoded 2-bit state and the four decoded one-hot lines, checks that they agree and that the sequence advances 0→1→2→3→0, and measures the dwell time of each state in `clk` cycles. It asserts lock once a full clean cycle has been seen and raises sticky error flags for the timing-control logic and for lab readout.

## Interface
- `DWELL_WIDTH`, 16: width of the dwell counter and of the dwell outputs.

- `clk`  in  1  system clock; all inputs are synchronous to it.
- `reset_n`  in  1  synchronous, active-low reset.
- `state`  in  2  encoded phase from the sequencer.
- `state_0`..`state_3`  in  1 each  decoded one-hot phase lines.
- `clear_errors`  in  1  synchronous clear of the sticky error flags.
- `dwell_0`..`dwell_3`  out  DWELL_WIDTH each  last complete dwell of each state, in cycles.
- `locked`  out  1  high while the sequence is tracked with no errors.
- `cycle_done`  out  1  one-cycle pulse on each counted 3→0 wrap.
- `cycle_count`  out  32  number of `cycle_done` pulses; wraps modulo 2^32.
- `err_sequence`  out  1  sticky; illegal transition seen.
- `err_decode`  out  1  sticky; the one-hot lines are not exactly one-hot, or disagree with `state`.
- `err_overflow`  out  1  sticky; the dwell counter saturated.

## Operation
- **Input stage:** `state` and the one-hot lines are registered into `s_q`. The previous `s_q` is held in `p_q`.
- **Transition test:** a transition is `s_q != p_q`. It is legal only if `s_q == p_q + 1` mod 4, so 3→0 is legal.
- **Decode test:** evaluated on every registered sample. It fails if the one-hot lines do not have exactly one bit set, or if the set bit index is not `s_q`.
- **Dwell counter `cnt`:**
  - Loads 1 on a registered transition.
  - Otherwise increments, saturating at 2^DWELL_WIDTH−1.
  - Reaching saturation sets `err_overflow`.
- **FSM states:**
  - **SEARCH** (reset state): waits for a legal transition into state 0, then goes to TRACK.
  - **TRACK:** accepts legal transitions 0→1, 1→2, 2→3. On 3→0 it goes to LOCKED and pulses `cycle_done`.
  - **LOCKED:** each legal 3→0 pulses `cycle_done`.
  - **Fault in TRACK or LOCKED:** an illegal transition, a decode failure, or saturation returns the FSM to SEARCH in the same cycle.
- **Dwell capture:** on a legal transition while in TRACK or LOCKED, `dwell_<p_q> <= cnt`.
  - In SEARCH the dwell outputs do not update, because the first partial dwell is discarded.
  - The transition SEARCH→TRACK does not capture a dwell.
- **Outputs:**
  - `locked` = (FSM == LOCKED).
  - `cycle_count` increments with each `cycle_done`.
- **Error flags:**
  - Each flag is sticky in every FSM state.
  - `clear_errors` clears all three flags.
  - If a new error occurs in the same cycle as `clear_errors`, the new error wins and its flag stays set.
- **Reset values:** FSM=SEARCH; `s_q`, `p_q`, `cnt`, all dwell outputs, `locked`, `cycle_done`, `cycle_count` and all error flags = 0.
- **Reset mid-operation:** reset has priority over everything. Lock is lost immediately, and SEARCH is re-entered on the next edge.

## Timing
- **Input latency:** an input change set up before edge k appears in `s_q` at edge k.
- **Flag and FSM latency:** flags, FSM state, `cnt`, dwell capture and `cycle_done` register at edge k+1, i.e. two edges after the input change.
- **Dwell value:** if the input holds a state for D edges, the captured dwell is exactly D (for D < 2^DWELL_WIDTH−1).
- **Saturation:** `err_overflow` rises on the edge where `cnt` becomes 2^DWELL_WIDTH−1.
- **`cycle_done`:** exactly one cycle wide, and never two pulses closer together than 4 cycles.
- **Lock from reset:** with a clean sequence starting in state 0, lock is reached at the second 3→0 wrap, so `cycle_count` = 1 at lock.

## Test plan
- **Nominal sequence:** reset, then 0,1,2,3 repeated with 10 cycles each.
  - `locked` rises 2 cycles after the second 3→0 input change.
  - All dwell outputs = 10.
  - `cycle_count` increments by 1 every 40 cycles.
  - No errors.
- **Illegal skip:** while LOCKED, apply 1→3.
  - `err_sequence` = 1 and `locked` = 0, two cycles later.
  - Relock occurs at the second following 3→0.
- **Decode fault:** set `state`=2 with `state_1` high.
  - `err_decode` = 1 and the FSM returns to SEARCH.
  - A later decode fault coinciding with `clear_errors` leaves `err_decode` = 1.
- **Stuck sequencer:** DWELL_WIDTH=4 and the state held for 20 cycles.
  - `err_overflow` rises when `cnt` reaches 15 and `locked` drops.
  - The dwell output of the stuck state is unchanged.
- **Asymmetric dwells:** dwells of 3, 7, 1 and 12 cycles.
  - `dwell_0..3` = 3, 7, 1, 12.
  - A dwell of 1 cycle still counts as a legal transition.
- **Reset mid-lock:** pull `reset_n` low for 1 cycle while LOCKED.
  - All outputs = 0 on the next edge.
  - Clean input afterwards re-locks with `cycle_count` = 1.
